// File: rtl/conc_pkg.sv
// ============================================================================
//  conc_pkg : shared encodings for the conquest stimulus player
//  Rev 1.0
// ============================================================================
`default_nettype none

package conc_pkg;

    localparam int VEC_W_DEF   = 17;
    localparam int OBS_BIT_DEF = 16;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_LOOP    = 2'b01;
    localparam logic [1:0] MODE_STEP    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/conc_vec_ram.sv
// ============================================================================
//  conc_vec_ram : DEPTH x VEC_W RAM, one write port, one registered read port
//  Rev 1.0
// ============================================================================
`default_nettype none

module conc_vec_ram #(
    parameter int VEC_W  = 17,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [VEC_W-1:0]  wdata,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr,
    output logic [VEC_W-1:0]  rdata
);

    logic [VEC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the stimulus output: it holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/conc_stim_player.sv
// ============================================================================
//  conc_stim_player : replays a loaded vector RAM onto a DUT input bus
//  Rev 1.0
// ============================================================================
`default_nettype none

module conc_stim_player
    import conc_pkg::*;
#(
    parameter int VEC_W   = VEC_W_DEF,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OBS_BIT = OBS_BIT_DEF,
    parameter int HOLD_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              rst_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_adr_i,
    input  logic [VEC_W-1:0]  ld_dat_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              step_i,
    input  logic [1:0]        mode_i,
    input  logic [ADDR_W-1:0] end_adr_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [VEC_W-1:0]  vec_o,
    output logic              vec_vld_o,
    output logic              obs_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       wrap_cnt_o,
    output logic              ld_err_o
);

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [ADDR_W-1:0]  r_end;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_next;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_vld;
    logic [15:0]        r_wrap;
    logic               r_ld_err;

    logic               w_idle_or_done;
    logic               w_hold_done;
    logic               w_last;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_rd_adr;
    logic [ADDR_W-1:0]  w_end_clamped;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_hold_done    = (r_hold_cnt == r_hold);
    assign w_last         = (r_pc == r_end);

    generate
        if (DEPTH < (1 << ADDR_W)) begin : g_clamp
            assign w_end_clamped = (32'(end_adr_i) > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : end_adr_i;
        end else begin : g_no_clamp
            assign w_end_clamped = end_adr_i;
        end
    endgenerate

    // Prefetch on the last hold cycle so the next vector lands without a bubble
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_adr = r_next;
        if (!stop_i) begin
            if (r_state == ST_FETCH) begin
                w_rd_en = 1'b1;
            end else if (r_state == ST_RUN && w_hold_done && r_mode != MODE_STEP) begin
                if (!w_last) begin
                    w_rd_en  = 1'b1;
                    w_rd_adr = r_pc + ADDR_W'(1);
                end else if (r_mode == MODE_LOOP) begin
                    w_rd_en  = 1'b1;
                    w_rd_adr = '0;
                end
            end
        end
    end

    conc_vec_ram #(
        .VEC_W  (VEC_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (wb_clk_i),
        .rst_n (rst_i),
        .we    (ld_we_i && w_idle_or_done),
        .waddr (ld_adr_i),
        .wdata (ld_dat_i),
        .re    (w_rd_en),
        .clr   (stop_i),
        .raddr (w_rd_adr),
        .rdata (vec_o)
    );

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_ONESHOT;
            r_end      <= '0;
            r_pc       <= '0;
            r_next     <= '0;
            r_hold     <= '0;
            r_hold_cnt <= '0;
            r_vld      <= 1'b0;
            r_wrap     <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            r_ld_err <= ld_we_i && !w_idle_or_done;
            if (stop_i) begin
                r_state    <= ST_IDLE;
                r_vld      <= 1'b0;
                r_pc       <= '0;
                r_hold_cnt <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start_i) begin
                            r_mode  <= mode_i;
                            r_end   <= w_end_clamped;
                            r_hold  <= hold_i;
                            r_next  <= '0;
                            r_wrap  <= '0;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_pc       <= r_next;
                        r_vld      <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (!w_hold_done) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end else begin
                            r_hold_cnt <= '0;
                            if (w_last && r_mode != MODE_LOOP) begin
                                r_vld   <= 1'b0;
                                r_state <= ST_DONE;
                            end else if (r_mode == MODE_STEP) begin
                                r_state <= ST_WAIT_STEP;
                            end else if (w_last) begin
                                r_pc <= '0;
                                if (r_wrap != 16'hFFFF) begin
                                    r_wrap <= r_wrap + 16'd1;
                                end
                            end else begin
                                r_pc <= r_pc + ADDR_W'(1);
                            end
                        end
                    end
                    ST_WAIT_STEP: begin
                        if (step_i) begin
                            r_next  <= r_pc + ADDR_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign vec_vld_o  = r_vld;
    assign obs_o      = vec_o[OBS_BIT] & r_vld;
    assign pc_o       = r_pc;
    assign busy_o     = !w_idle_or_done;
    assign done_o     = (r_state == ST_DONE);
    assign wrap_cnt_o = r_wrap;
    assign ld_err_o   = r_ld_err;

endmodule

`default_nettype wire

// File: tb/tb_conc_stim_player.sv
// ============================================================================
//  tb_conc_stim_player : self-checking bench for conc_stim_player
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_conc_stim_player;
    import conc_pkg::*;

    localparam int VEC_W  = 17;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int HOLD_W = 8;

    logic              wb_clk_i = 1'b0;
    logic              rst_i    = 1'b0;
    logic              ld_we_i  = 1'b0;
    logic [ADDR_W-1:0] ld_adr_i = '0;
    logic [VEC_W-1:0]  ld_dat_i = '0;
    logic              start_i  = 1'b0;
    logic              stop_i   = 1'b0;
    logic              step_i   = 1'b0;
    logic [1:0]        mode_i   = 2'b00;
    logic [ADDR_W-1:0] end_adr_i = '0;
    logic [HOLD_W-1:0] hold_i   = '0;
    logic [VEC_W-1:0]  vec_o;
    logic              vec_vld_o;
    logic              obs_o;
    logic [ADDR_W-1:0] pc_o;
    logic              busy_o;
    logic              done_o;
    logic [15:0]       wrap_cnt_o;
    logic              ld_err_o;

    conc_stim_player dut (
        .wb_clk_i   (wb_clk_i),
        .rst_i      (rst_i),
        .ld_we_i    (ld_we_i),
        .ld_adr_i   (ld_adr_i),
        .ld_dat_i   (ld_dat_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .step_i     (step_i),
        .mode_i     (mode_i),
        .end_adr_i  (end_adr_i),
        .hold_i     (hold_i),
        .vec_o      (vec_o),
        .vec_vld_o  (vec_vld_o),
        .obs_o      (obs_o),
        .pc_o       (pc_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wrap_cnt_o (wrap_cnt_o),
        .ld_err_o   (ld_err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;
    logic [VEC_W-1:0] mem_m [DEPTH];

    typedef struct {
        logic [1:0] mode;
        int         end_adr;
        int         hold;
        int         ncyc;
        int         exp_vld;
        int         exp_wrap;
    } run_vec_t;

    typedef struct {
        int adr;
        int wraps;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic load(input int adr, input logic [VEC_W-1:0] d);
        ld_we_i  = 1'b1;
        ld_adr_i = ADDR_W'(adr);
        ld_dat_i = d;
        @(negedge wb_clk_i);
        ld_we_i  = 1'b0;
        mem_m[adr] = d;
        chk("ld_err_idle", 32'(ld_err_o), 0);
    endtask

    // Reference: expand each address into hold+1 cycles, cycling 0..end
    task automatic play(input logic [1:0] m, input int e, input int h, input int ncyc,
                        output int nvld, output int nobs, output int wrap_last);
        exp_t q[$];
        int   a = 0;
        int   w = 0;
        int   n;
        bit   is_loop = (m == MODE_LOOP);
        n = is_loop ? ncyc : (e + 1) * (h + 1);
        while (q.size() < n) begin
            for (int r = 0; r <= h && q.size() < n; r++) q.push_back('{a, w});
            if (a == e) begin a = 0; w++; end else a++;
        end
        nvld = 0; nobs = 0; wrap_last = 0;
        start_i = 1'b1; mode_i = m; end_adr_i = ADDR_W'(e); hold_i = HOLD_W'(h);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk("fetch_vld", 32'(vec_vld_o), 0);
        chk("fetch_busy", 32'(busy_o), 1);
        foreach (q[i]) begin
            @(negedge wb_clk_i);
            chk("vec", 32'(vec_o), 32'(mem_m[q[i].adr]));
            chk("pc", 32'(pc_o), 32'(q[i].adr));
            chk("vld", 32'(vec_vld_o), 1);
            chk("obs", 32'(obs_o), 32'(mem_m[q[i].adr][16]));
            chk("wrap", 32'(wrap_cnt_o), 32'(q[i].wraps));
            chk("busy", 32'(busy_o), 1);
            nvld += int'(vec_vld_o);
            nobs += int'(obs_o);
            wrap_last = int'(wrap_cnt_o);
        end
        if (is_loop) begin
            stop_i = 1'b1;
            @(negedge wb_clk_i);
            stop_i = 1'b0;
            chk("stop_vld", 32'(vec_vld_o), 0);
            chk("stop_vec", 32'(vec_o), 0);
            chk("stop_pc", 32'(pc_o), 0);
            chk("stop_busy", 32'(busy_o), 0);
            chk("stop_done", 32'(done_o), 0);
        end else begin
            @(negedge wb_clk_i);
            chk("end_done", 32'(done_o), 1);
            chk("end_vld", 32'(vec_vld_o), 0);
            chk("end_vec", 32'(vec_o), 32'(mem_m[e]));
            chk("end_pc", 32'(pc_o), 32'(e));
            chk("end_busy", 32'(busy_o), 0);
        end
    endtask

    run_vec_t tbl[7];
    int nvld, nobs, wlast;

    initial begin
        tbl[0] = '{MODE_ONESHOT, 3,  0, 0,  4,  0};
        tbl[1] = '{MODE_LOOP,    1,  2, 19, 19, 3};
        tbl[2] = '{2'b11,        2,  1, 0,  6,  0};
        tbl[3] = '{MODE_ONESHOT, 0,  0, 0,  1,  0};
        tbl[4] = '{MODE_LOOP,    0,  0, 5,  5,  4};
        tbl[5] = '{MODE_ONESHOT, 31, 0, 0,  32, 0};
        tbl[6] = '{MODE_LOOP,    2,  0, 7,  7,  2};

        @(negedge wb_clk_i);
        chk("rst_vec", 32'(vec_o), 0);
        chk("rst_vld", 32'(vec_vld_o), 0);
        chk("rst_pc", 32'(pc_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_wrap", 32'(wrap_cnt_o), 0);
        chk("rst_lderr", 32'(ld_err_o), 0);
        rst_i = 1'b1;
        @(negedge wb_clk_i);

        for (int i = 0; i < DEPTH; i++) load(i, VEC_W'(i + 1));

        foreach (tbl[i]) begin
            play(tbl[i].mode, tbl[i].end_adr, tbl[i].hold, tbl[i].ncyc, nvld, nobs, wlast);
            chk("tbl_nvld", 32'(nvld), 32'(tbl[i].exp_vld));
            chk("tbl_wrap", 32'(wlast), 32'(tbl[i].exp_wrap));
        end

        // Step mode: two steps walk through end=2, then done without a third
        start_i = 1'b1; mode_i = MODE_STEP; end_adr_i = 5'd2; hold_i = 8'd0;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        @(negedge wb_clk_i);
        chk("step_v0", 32'(vec_o), 32'(mem_m[0]));
        repeat (3) begin
            @(negedge wb_clk_i);
            chk("step_hold0", 32'(vec_o), 32'(mem_m[0]));
            chk("step_hold0_vld", 32'(vec_vld_o), 1);
        end
        step_i = 1'b1;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        chk("step_lat0", 32'(vec_o), 32'(mem_m[0]));
        @(negedge wb_clk_i);
        chk("step_v1", 32'(vec_o), 32'(mem_m[1]));
        chk("step_pc1", 32'(pc_o), 1);
        repeat (2) begin
            @(negedge wb_clk_i);
            chk("step_hold1", 32'(vec_o), 32'(mem_m[1]));
        end
        step_i = 1'b1;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        chk("step_lat1", 32'(vec_o), 32'(mem_m[1]));
        @(negedge wb_clk_i);
        chk("step_v2", 32'(vec_o), 32'(mem_m[2]));
        chk("step_v2_vld", 32'(vec_vld_o), 1);
        @(negedge wb_clk_i);
        chk("step_done", 32'(done_o), 1);
        chk("step_done_vld", 32'(vec_vld_o), 0);
        step_i = 1'b1;
        @(negedge wb_clk_i);
        step_i = 1'b0;
        chk("step_ignored", 32'(vec_o), 32'(mem_m[2]));
        chk("step_ignored_done", 32'(done_o), 1);

        // stop beats a simultaneous step
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        stop_i = 1'b1; step_i = 1'b1;
        @(negedge wb_clk_i);
        stop_i = 1'b0; step_i = 1'b0;
        chk("stopstep_busy", 32'(busy_o), 0);
        chk("stopstep_vec", 32'(vec_o), 0);
        chk("stopstep_vld", 32'(vec_vld_o), 0);

        // Observe flag on vector 2 only
        load(2, 17'h10002);
        play(MODE_ONESHOT, 3, 1, 0, nvld, nobs, wlast);
        chk("obs_cycles", 32'(nobs), 2);

        // Write while running is dropped and flagged
        start_i = 1'b1; mode_i = MODE_ONESHOT; end_adr_i = 5'd3; hold_i = 8'd5;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        @(negedge wb_clk_i);
        ld_we_i = 1'b1; ld_adr_i = 5'd1; ld_dat_i = 17'h1ABCD;
        @(negedge wb_clk_i);
        ld_we_i = 1'b0;
        chk("lderr_pulse", 32'(ld_err_o), 1);
        @(negedge wb_clk_i);
        chk("lderr_clear", 32'(ld_err_o), 0);
        begin
            int budget = 200;
            while (!done_o && budget > 0) begin
                @(negedge wb_clk_i);
                budget--;
            end
            chk("lderr_run_done", 32'(done_o), 1);
        end
        play(MODE_ONESHOT, 3, 0, 0, nvld, nobs, wlast);

        // start together with stop stays idle
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        chk("startstop_busy", 32'(busy_o), 0);
        @(negedge wb_clk_i);
        chk("startstop_busy2", 32'(busy_o), 0);
        chk("startstop_done", 32'(done_o), 0);

        // Asynchronous reset mid-run
        start_i = 1'b1; mode_i = MODE_LOOP; end_adr_i = 5'd0; hold_i = 8'd5;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge wb_clk_i);
        chk("prerst_wrap", 32'(wrap_cnt_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_vec", 32'(vec_o), 0);
        chk("arst_vld", 32'(vec_vld_o), 0);
        chk("arst_pc", 32'(pc_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_wrap", 32'(wrap_cnt_o), 0);
        @(negedge wb_clk_i);
        rst_i = 1'b1;
        @(negedge wb_clk_i);
        play(MODE_ONESHOT, 3, 1, 0, nvld, nobs, wlast);

        // Randomized runs against the reference expansion
        for (int r = 0; r < 6; r++) begin
            int e = $urandom_range(0, DEPTH - 1);
            int h = $urandom_range(0, 3);
            int n = $urandom_range(1, 70);
            logic [1:0] m = 2'($urandom_range(0, 3));
            if (m == MODE_STEP) m = MODE_LOOP;
            for (int i = 0; i <= e; i++) load(i, VEC_W'($urandom));
            play(m, e, h, n, nvld, nobs, wlast);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
